// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit for the mini-SRC datapath. Steps fetch (T0-T2) and
// the per-class execute steps (T3-T7), one step per clk edge, and decodes
// every datapath control strobe from the current step and the opcode in IR.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-low reset (forces RESET)
//   IR[31:0]     instruction register, opcode in IR[31:27]
//   CON          branch condition flip-flop output
//   Stop         halt request, only honoured in T0
//   Run          high in T0-T7
//   Gra..BaOut   register select / encode controls
//   *out         bus drivers
//   *in          register loads
//   IncPC, MDRread, WRen, ZLowSelect, ZHighSelect  misc strobes
//   ALU_opcode   ALU operation, zero whenever Zin is low
// ---------------------------------------------------------------------------
// state  | meaning
// RESET  | held in reset, all outputs low
// T0     | fetch: PC -> MAR, increment PC (or go to HALT on Stop)
// T1     | fetch: memory -> MDR
// T2     | fetch: MDR -> IR
// T3..T7 | execute steps, content depends on opcode class
// HALT   | stopped, all outputs low until reset
// ---------------------------------------------------------------------------
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BaOut,
    output logic        PCout,
    output logic        MDRout,
    output logic        HIout,
    output logic        Loout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        Cout,
    output logic        InPortout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        Loin,
    output logic        CON_ff_in,
    output logic        IncPC,
    output logic        MDRread,
    output logic        WRen,
    output logic        ZLowSelect,
    output logic        ZHighSelect,
    output logic [4:0]  ALU_opcode
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     r_state;
    logic [4:0] w_op;
    logic       w_unused_ir;
    logic       w_is_alu, w_is_imm, w_is_ld, w_is_ldi, w_is_st, w_is_muldiv;
    logic       w_is_negnot, w_is_br, w_is_jr, w_is_in, w_is_mfhi, w_is_mflo;
    logic       w_is_halt;
    logic [4:0] w_imm_alu;

    assign w_op        = IR[31:27];
    assign w_unused_ir = ^IR[26:0];

    assign w_is_alu    = (w_op >= OP_ADD) && (w_op <= OP_ROL);
    assign w_is_imm    = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
    assign w_is_ld     = (w_op == OP_LD);
    assign w_is_ldi    = (w_op == OP_LDI);
    assign w_is_st     = (w_op == OP_ST);
    assign w_is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
    assign w_is_negnot = (w_op == OP_NEG) || (w_op == OP_NOT);
    assign w_is_br     = (w_op == OP_BR);
    assign w_is_jr     = (w_op == OP_JR);
    assign w_is_in     = (w_op == OP_IN);
    assign w_is_mfhi   = (w_op == OP_MFHI);
    assign w_is_mflo   = (w_op == OP_MFLO);
    assign w_is_halt   = (w_op == OP_HALT);

    // Immediate forms reuse the ALU with the register-form opcode.
    assign w_imm_alu = (w_op == OP_ADDI) ? OP_ADD :
                       (w_op == OP_ANDI) ? OP_AND : OP_OR;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= Stop ? S_HALT : S_T1;
                S_T1:    r_state <= S_T2;
                S_T2:    r_state <= S_T3;
                S_T3: begin
                    if (w_is_halt)
                        r_state <= S_HALT;
                    else if (w_is_alu || w_is_imm || w_is_ld || w_is_ldi || w_is_st ||
                             w_is_muldiv || w_is_negnot || w_is_br)
                        r_state <= S_T4;
                    else
                        r_state <= S_T0;
                end
                // every class that reaches T4 also has a T5
                S_T4:    r_state <= S_T5;
                S_T5:    r_state <= (w_is_ld || w_is_st || w_is_muldiv || w_is_br) ? S_T6 : S_T0;
                S_T6:    r_state <= (w_is_ld || w_is_st) ? S_T7 : S_T0;
                S_T7:    r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        Run = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BaOut = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; HIout = 1'b0; Loout = 1'b0; ZHIout = 1'b0;
        ZLOout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
        PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        HIin = 1'b0; Loin = 1'b0; CON_ff_in = 1'b0;
        IncPC = 1'b0; MDRread = 1'b0; WRen = 1'b0; ZLowSelect = 1'b0; ZHighSelect = 1'b0;
        ALU_opcode = 5'b00000;

        case (r_state)
            S_T0: begin
                Run = 1'b1;
                // a pending Stop suppresses the fetch so PC is not advanced
                if (!Stop) begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                end
            end
            S_T1: begin
                Run = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (w_is_alu || w_is_imm || w_is_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_is_ld || w_is_ldi || w_is_st) begin
                    Grb = 1'b1; BaOut = 1'b1; Yin = 1'b1;
                end else if (w_is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_is_br) begin
                    Grb = 1'b1; Rout = 1'b1; CON_ff_in = 1'b1;
                end else if (w_is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (w_is_in) begin
                    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_mfhi) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_mflo) begin
                    Loout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T4: begin
                Run = 1'b1;
                if (w_is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = w_op;
                end else if (w_is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; ALU_opcode = w_imm_alu;
                end else if (w_is_ld || w_is_ldi || w_is_st) begin
                    Cout = 1'b1; Zin = 1'b1; ALU_opcode = OP_ADD;
                end else if (w_is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = w_op;
                end else if (w_is_negnot) begin
                    Zin = 1'b1; ALU_opcode = w_op;
                end else if (w_is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                Run = 1'b1;
                if (w_is_alu || w_is_imm || w_is_ldi || w_is_negnot) begin
                    ZLOout = 1'b1; ZLowSelect = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_ld || w_is_st) begin
                    ZLOout = 1'b1; ZLowSelect = 1'b1; MARin = 1'b1;
                end else if (w_is_muldiv) begin
                    ZLOout = 1'b1; ZLowSelect = 1'b1; Loin = 1'b1;
                end else if (w_is_br) begin
                    Cout = 1'b1; Zin = 1'b1; ALU_opcode = OP_ADD;
                end
            end
            S_T6: begin
                Run = 1'b1;
                if (w_is_ld) begin
                    MDRread = 1'b1; MDRin = 1'b1;
                end else if (w_is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (w_is_muldiv) begin
                    ZHIout = 1'b1; ZHighSelect = 1'b1; HIin = 1'b1;
                end else if (w_is_br) begin
                    ZLOout = 1'b1; ZLowSelect = 1'b1; PCin = CON;
                end
            end
            S_T7: begin
                Run = 1'b1;
                if (w_is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_st) begin
                    WRen = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the datapath's control inputs. It steps through fetch, decode and execute for the mini-SRC instruction subset, one control step per clock. It reads the instruction register and the CON flip-flop, and produces every register enable, bus-select, ALU-opcode and memory-strobe signal the datapath consumes.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  synchronous, active-low reset
- IR  in  32  instruction register contents (op = IR[31:27])
- CON  in  1  CON flip-flop output (branch condition)
- Stop  in  1  external halt request
- Run  out  1  high while executing
- Gra, Grb, Grc, Rin, Rout, BaOut  out  1 each  register select/encode controls
- PCout, MDRout, HIout, Loout, ZHIout, ZLOout, Cout, InPortout  out  1 each  bus drivers
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, Loin, CON_ff_in  out  1 each  register loads
- IncPC, MDRread, WRen, ZLowSelect, ZHighSelect  out  1 each  PC increment, MDR source select, memory write, Z half selects
- ALU_opcode  out  5  ALU operation; 00000 whenever Zin=0

## Operation
- States: RESET, T0–T7, HALT. Outputs are decoded combinationally from the state register and op. Every output not listed for a step is 0.
- Fetch:
  - T0: PCout, MARin, IncPC
  - T1: MDRread, MDRin
  - T2: MDRout, IRin
- T2 → T3 always. Each class returns to T0 after its last listed step.
- add/sub/and/or/shr/shra/shl/ror/rol (00011–01011):
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zin, ALU_opcode=op
  - T5: ZLOout, ZLowSelect, Gra, Rin
- addi/andi/ori (01100/01101/01110):
  - as R-type, except T4 uses Cout instead of Grc/Rout
  - ALU_opcode = 00011 / 00101 / 00110 respectively
- ld 00000:
  - T3: Grb, BaOut, Yin
  - T4: Cout, Zin, ALU_opcode=00011
  - T5: ZLOout, ZLowSelect, MARin
  - T6: MDRread, MDRin
  - T7: MDRout, Gra, Rin
- ldi 00001: T3–T4 as ld; T5: ZLOout, ZLowSelect, Gra, Rin
- st 00010:
  - T3–T5 as ld
  - T6: Gra, Rout, MDRin (MDRread=0)
  - T7: WRen
- mul/div (01111/10000):
  - T3: Gra, Rout, Yin
  - T4: Grb, Rout, Zin, ALU_opcode=op
  - T5: ZLOout, ZLowSelect, Loin
  - T6: ZHIout, ZHighSelect, HIin
- neg/not (10001/10010):
  - T3: Grb, Rout, Yin
  - T4: Zin, ALU_opcode=op
  - T5: ZLOout, ZLowSelect, Gra, Rin
- br 10011:
  - T3: Grb, Rout, CON_ff_in
  - T4: PCout, Yin
  - T5: Cout, Zin, ALU_opcode=00011
  - T6: ZLOout, ZLowSelect, and PCin only if CON=1
- jr 10100: T3: Gra, Rout, PCin
- in 10110: T3: InPortout, Gra, Rin
- mfhi 11000: T3: HIout, Gra, Rin
- mflo 11001: T3: Loout, Gra, Rin
- nop 11010, plus all unlisted opcodes (10101, 10111, 11100–11111): T3 with all outputs 0, then T0.
- halt 11011: T3 → HALT.
- HALT: all outputs 0, Run=0. The state is held until a reset.
- Stop is sampled only in T0. If Stop=1, T0's outputs are suppressed and the next state is HALT. Stop=1 in any other state has no effect until the next T0.

## Timing
- Any edge with clr=0 sets state←RESET, from any state, including mid-instruction. RESET drives all outputs 0 and Run=0.
- The first edge with clr=1 moves RESET→T0. Run=1 in T0–T7.
- One control step per clock. IR must be stable from T3 until the instruction ends.
- Instruction lengths, fetch included:
  - 4 cycles: jr, in, mfhi, mflo, nop, unlisted
  - 6 cycles: ALU, immediate, ldi, neg/not
  - 7 cycles: mul/div, br
  - 8 cycles: ld, st
- Memory is assumed to return data within one cycle of MARin, so there are no wait states.
- CON is sampled in T6 of br. It was latched by CON_ff_in in T3.

## Test plan
- Reset: hold clr=0 for 3 cycles → all outputs 0 and Run=0. Release clr → T0 asserts PCout=MARin=IncPC=1 and Run=1.
- add (IR=0x18918000, op 00011): check T3 Grb·Rout·Yin; T4 Grc·Rout·Zin with ALU_opcode=00011; T5 ZLOout·Gra·Rin; the next cycle is T0.
- ld (op 00000): 8-cycle sequence. MDRread=1 only in T1 and T6; BaOut=1 only in T3; WRen=0 throughout.
- st (op 00010): WRen=1 only in T7. MDRread=0 in T6 while MDRin=1.
- br (op 10011): CON=1 → PCin=1 in T6. Repeat with CON=0 → PCin=0 in T6, and the next state is still T0.
- Halt cases:
  - halt opcode → HALT with Run=0, stays 20 cycles
  - Stop=1 during T4 → ignored until the next T0, then HALT
  - clr=0 asserted during T5 of mul → RESET on the next edge, then T0
